// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the adder, the result stage and its consumer.
// Both sides use valid/ready: a transfer happens on a rising clock edge
// where valid and ready are both high. A producer keeps valid and data
// stable until ready is seen. Ready never depends on valid in the same cycle.
interface alu_result_stage_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_s;
  logic              in_cary;
  logic              in_of;
  logic              in_eq;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_s;
  logic              out_cary;
  logic              out_of;
  logic              out_eq;

  // Result stage view: consumes in_*, produces out_*.
  modport slave (
    input  in_valid, in_s, in_cary, in_of, in_eq, out_ready,
    output in_ready, out_valid, out_s, out_cary, out_of, out_eq
  );

  // Environment view: the adder side and the consumer side together.
  modport master (
    output in_valid, in_s, in_cary, in_of, in_eq, out_ready,
    input  in_ready, out_valid, out_s, out_cary, out_of, out_eq
  );
endinterface

// File: rtl/alu_result_stage.sv
// Registered output stage behind the 32-bit adder: a 2-entry in-order
// buffer with valid/ready on both sides, plus sticky carry/overflow bits
// and a saturating overflow-event counter.
module alu_result_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_result_stage_if.slave bus,
  input  logic             clr_sticky,
  output logic             sticky_cary,
  output logic             sticky_of,
  output logic [CNT_W-1:0] of_count
);
  localparam int ENT_W = DATA_W + 3;

  logic [ENT_W-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_occ;
  logic             r_sticky_cary;
  logic             r_sticky_of;
  logic [CNT_W-1:0] r_of_count;

  logic             w_push;
  logic             w_pop;
  logic             w_in_ready;
  logic             w_out_valid;
  logic [ENT_W-1:0] w_wr_data;
  logic [ENT_W-1:0] w_head;
  logic             w_of_evt;
  logic             w_cary_evt;

  // Handshake flags come only from registered occupancy, so ready has no
  // path from out_ready and nothing on the outputs follows an input directly.
  always_comb begin
    w_in_ready  = (r_occ != 2'd2);
    w_out_valid = (r_occ != 2'd0);
    w_push      = bus.in_valid & w_in_ready;
    w_pop       = w_out_valid & bus.out_ready;
    w_wr_data   = {bus.in_s, bus.in_cary, bus.in_of, bus.in_eq};
    w_head      = r_mem[r_rd_ptr];
    w_of_evt    = w_push & bus.in_of;
    w_cary_evt  = w_push & bus.in_cary;
  end

  // Storage and pointers; reset wipes the entries so out_* read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_wr_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
    end
  end

  // Occupancy: push and pop together leave it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= 2'd0;
    end else if (w_push && !w_pop) begin
      r_occ <= r_occ + 2'd1;
    end else if (w_pop && !w_push) begin
      r_occ <= r_occ - 2'd1;
    end
  end

  // Sticky status and counter follow pushes; a clear in the same cycle as
  // a push keeps that push's contribution.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky_cary <= 1'b0;
      r_sticky_of   <= 1'b0;
      r_of_count    <= '0;
    end else if (clr_sticky) begin
      r_sticky_cary <= w_cary_evt;
      r_sticky_of   <= w_of_evt;
      r_of_count    <= w_of_evt ? CNT_W'(1) : '0;
    end else begin
      r_sticky_cary <= r_sticky_cary | w_cary_evt;
      r_sticky_of   <= r_sticky_of | w_of_evt;
      if (w_of_evt && (r_of_count != {CNT_W{1'b1}}))
        r_of_count <= r_of_count + CNT_W'(1);
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_s     = w_head[ENT_W-1:3];
  assign bus.out_cary  = w_head[2];
  assign bus.out_of    = w_head[1];
  assign bus.out_eq    = w_head[0];
  assign sticky_cary   = r_sticky_cary;
  assign sticky_of     = r_sticky_of;
  assign of_count      = r_of_count;
endmodule
